// File: rtl/dco_ctrl_encoder.sv
// rtl/dco_ctrl_encoder.sv - DCO tuning word to coarse/fine bank encoder with sigma-delta fine dither
//
// Purpose: clamps the loop filter's signed tuning word onto an offset-binary range and splits it into
// a binary coarse bank code and a thermometer fine bank. The fractional LSBs are dithered onto the fine
// bank by a first-order sigma-delta. After every coarse step the dither is frozen for SETTLE_CYC cycles.
// Optional macro DCO_ENC_DWA_EN: rotate fine-bank element selection (data-weighted averaging).
//
// Ports:
//   refclk       in   loop reference clock, all state on posedge
//   reset        in   asynchronous active-high reset
//   dctrl        in   signed 32-bit tuning word, 0 = centre frequency
//   dctrl_valid  in   dctrl is sampled on this edge
//   hold         in   freeze all outputs, dither and settle counter
//   coarse_code  out  binary coarse bank code
//   fine_therm   out  fine bank unit-element enables
//   sat_hi       out  last accepted word clamped high
//   sat_lo       out  last accepted word clamped low
//   settling     out  dither frozen after a coarse change
//   coarse_chg   out  one-cycle pulse when coarse_code changes
module dco_ctrl_encoder #(
    parameter int FRAC_BITS   = 4,
    parameter int FINE_BITS   = 6,
    parameter int COARSE_BITS = 6,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                        refclk,
    input  logic                        reset,
    input  logic signed [31:0]          dctrl,
    input  logic                        dctrl_valid,
    input  logic                        hold,
    output logic [COARSE_BITS-1:0]      coarse_code,
    output logic [(2**FINE_BITS)-1:0]   fine_therm,
    output logic                        sat_hi,
    output logic                        sat_lo,
    output logic                        settling,
    output logic                        coarse_chg
);

    localparam int TOTAL = FRAC_BITS + FINE_BITS + COARSE_BITS;
    localparam int NFINE = 2**FINE_BITS;
    localparam logic signed [32:0] OFFSET = 33'sd1 <<< (TOTAL - 1);
    localparam logic signed [32:0] U_MAX  = (33'sd1 <<< TOTAL) - 33'sd1;
    localparam logic [COARSE_BITS-1:0] COARSE_RST = {1'b1, {(COARSE_BITS-1){1'b0}}};
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC);

    typedef enum logic {TRACK, SETTLE} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [FRAC_BITS-1:0]     acc_q, acc_d;
    logic [COARSE_BITS-1:0]   coarse_q, coarse_d;
    logic [NFINE-1:0]         fine_q, fine_d;
    logic                     sat_hi_q, sat_hi_d;
    logic                     sat_lo_q, sat_lo_d;
    logic                     chg_q, chg_d;

    logic signed [32:0]       u_raw;
    logic [TOTAL-1:0]         u_c;
    logic [FRAC_BITS-1:0]     frac;
    logic [FINE_BITS-1:0]     fine_f;
    logic [COARSE_BITS-1:0]   coarse_f;
    logic [FRAC_BITS:0]       sum;
    logic                     carry;
    logic [FINE_BITS:0]       fine_n;
    logic [NFINE-1:0]         ones;
    logic [NFINE-1:0]         mask;
    logic                     lo_c, hi_c;

`ifdef DCO_ENC_DWA_EN
    logic [FINE_BITS-1:0]     ptr_q, ptr_d;
    logic [2*NFINE-1:0]       rot;
`endif

    // Offset-binary conversion is done one bit wider than the input so the
    // sign of the sum directly flags a low clamp.
    assign u_raw = $signed({dctrl[31], dctrl}) + OFFSET;

    always_comb begin
        lo_c     = (u_raw < 33'sd0);
        hi_c     = (u_raw > U_MAX);
        u_c      = lo_c ? '0 : (hi_c ? '1 : u_raw[TOTAL-1:0]);
        frac     = u_c[FRAC_BITS-1:0];
        fine_f   = u_c[FRAC_BITS +: FINE_BITS];
        coarse_f = u_c[TOTAL-1 -: COARSE_BITS];
        sum      = {1'b0, acc_q} + {1'b0, frac};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        chg_d    = 1'b0;
        carry    = 1'b0;
        fine_n   = '0;
        ones     = '1;
        mask     = '0;
`ifdef DCO_ENC_DWA_EN
        ptr_d    = ptr_q;
        rot      = '0;
`endif
        if (!hold) begin
            if (state_q == SETTLE) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = TRACK;
                end
            end
            if (dctrl_valid) begin
                sat_hi_d = hi_c;
                sat_lo_d = lo_c;
                if (coarse_f != coarse_q) begin
                    // A coarse step overrides any pending settle expiry.
                    coarse_d = coarse_f;
                    chg_d    = 1'b1;
                    acc_d    = '0;
                    cnt_d    = SETTLE_INIT;
                    state_d  = SETTLE;
                end else if (state_q == TRACK) begin
                    acc_d = sum[FRAC_BITS-1:0];
                    carry = sum[FRAC_BITS];
                end else begin
                    acc_d = '0;
                end
                fine_n = {1'b0, fine_f} + {{FINE_BITS{1'b0}}, carry};
                // fine_n may equal NFINE; the shift then clears all bits and mask becomes all ones.
                mask   = ~(ones << fine_n);
`ifdef DCO_ENC_DWA_EN
                rot    = {mask, mask} << ptr_q;
                fine_d = rot[2*NFINE-1:NFINE];
                ptr_d  = ptr_q + fine_n[FINE_BITS-1:0];
`else
                fine_d = mask;
`endif
            end
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q  <= TRACK;
            cnt_q    <= '0;
            acc_q    <= '0;
            coarse_q <= COARSE_RST;
            fine_q   <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
            chg_q    <= chg_d;
        end
    end

`ifdef DCO_ENC_DWA_EN
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign coarse_code = coarse_q;
    assign fine_therm  = fine_q;
    assign sat_hi      = sat_hi_q;
    assign sat_lo      = sat_lo_q;
    assign settling    = (state_q == SETTLE);
    assign coarse_chg  = chg_q;

endmodule

// File: tb/tb_dco_ctrl_encoder.sv
// tb/tb_dco_ctrl_encoder.sv - scoreboard bench for dco_ctrl_encoder
module tb_dco_ctrl_encoder;

    logic               refclk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] dctrl = '0;
    logic               dctrl_valid = 1'b0;
    logic               hold = 1'b0;
    logic [5:0]         coarse_code;
    logic [63:0]        fine_therm;
    logic               sat_hi, sat_lo, settling, coarse_chg;

    dco_ctrl_encoder dut (
        .refclk      (refclk),
        .reset       (reset),
        .dctrl       (dctrl),
        .dctrl_valid (dctrl_valid),
        .hold        (hold),
        .coarse_code (coarse_code),
        .fine_therm  (fine_therm),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .settling    (settling),
        .coarse_chg  (coarse_chg)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [5:0]  coarse;
        logic [63:0] therm;
        logic        sh, sl, st, chg;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_tag = 0;

    // Reference model state, kept as plain integers.
    int          m_acc, m_cnt, m_coarse, m_ptr;
    bit          m_settle, m_sh, m_sl, m_chg;
    logic [63:0] m_therm;

    // Tagged-window statistics gathered from the DUT by the monitor.
    int t2_three = 0, t2_two = 0;
    int t3_settle = 0, t3_chg = 0;
    int t5_settle = 0, t5_chg = 0;
    logic [63:0] dwa_seen[3];
    int dwa_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] therm_of(input int n, input int p);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[(p + k) % 64] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_coarse = 32; m_ptr = 0;
        m_settle = 0; m_sh = 0; m_sl = 0; m_chg = 0; m_therm = '0;
    endtask

    task automatic model_edge(input bit r, input bit v, input bit h, input longint d);
        longint u;
        int frac, fine, co, carry, n;
        bit was_settle;
        if (r) begin
            model_reset();
            return;
        end
        m_chg = 0;
        if (h) return;
        was_settle = m_settle;
        if (m_settle) begin
            m_cnt--;
            if (m_cnt == 0) m_settle = 0;
        end
        if (v) begin
            u = d + 32768;
            m_sl = (u < 0);
            m_sh = (u > 65535);
            if (u < 0) u = 0;
            if (u > 65535) u = 65535;
            frac = int'(u % 16);
            fine = int'((u / 16) % 64);
            co   = int'(u / 1024);
            carry = 0;
            if (co != m_coarse) begin
                m_coarse = co; m_chg = 1; m_acc = 0;
                m_cnt = 4; m_settle = 1;
            end else if (!was_settle) begin
                m_acc = m_acc + frac;
                if (m_acc >= 16) begin
                    carry = 1;
                    m_acc -= 16;
                end
            end else begin
                m_acc = 0;
            end
            n = fine + carry;
            m_therm = therm_of(n, m_ptr);
`ifdef DCO_ENC_DWA_EN
            m_ptr = (m_ptr + n) % 64;
`endif
        end
    endtask

    task automatic step(input bit r, input bit v, input bit h, input longint d);
        exp_t e;
        @(negedge refclk);
        reset = r;
        dctrl_valid = v;
        hold = h;
        dctrl = 32'(d);
        @(posedge refclk);
        model_edge(r, v, h, d);
        e.coarse = 6'(m_coarse);
        e.therm  = m_therm;
        e.sh = m_sh; e.sl = m_sl; e.st = m_settle; e.chg = m_chg;
        e.tag = cur_tag;
        q.push_back(e);
    endtask

    always @(negedge refclk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("coarse_code", 64'(coarse_code), 64'(e.coarse));
            chk("fine_therm",  fine_therm, e.therm);
            chk("sat_hi",      64'(sat_hi), 64'(e.sh));
            chk("sat_lo",      64'(sat_lo), 64'(e.sl));
            chk("settling",    64'(settling), 64'(e.st));
            chk("coarse_chg",  64'(coarse_chg), 64'(e.chg));
            case (e.tag)
                2: begin
                    if ($countones(fine_therm) == 3) t2_three++;
                    if ($countones(fine_therm) == 2) t2_two++;
                end
                3: begin
                    if (settling) t3_settle++;
                    if (coarse_chg) t3_chg++;
                end
                5: begin
                    if (settling) t5_settle++;
                    if (coarse_chg) t5_chg++;
                end
                6: begin
                    if (dwa_idx < 3) dwa_seen[dwa_idx] = fine_therm;
                    dwa_idx++;
                end
                default: ;
            endcase
        end
    end

    initial begin
        model_reset();
        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // Constant word 37: 2 fine units plus 5/16 dither.
        cur_tag = 2;
        for (int i = 0; i < 16; i++) step(0, 1, 0, 37);
        cur_tag = 0;

        // Coarse step 32 -> 33 and the settle window.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        cur_tag = 3;
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1024);
        cur_tag = 0;

        // Saturation both ways.
        for (int i = 0; i < 12; i++) step(0, 1, 0, 40000);
        for (int i = 0; i < 8; i++) step(0, 1, 0, -40000);

        // Hold in the middle of a settle window with changing input.
        step(0, 1, 0, 0);
        step(0, 1, 0, 5);
        cur_tag = 5;
        for (int i = 0; i < 10; i++) step(0, 1, 1, longint'($urandom_range(60000)) - 30000);
        cur_tag = 0;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 7);

        // Asynchronous reset while settling.
        step(0, 1, 0, 3000);
        @(negedge refclk);
        #2 reset = 1'b1;
        #1;
        chk("async_coarse",   64'(coarse_code), 64'd32);
        chk("async_therm",    fine_therm, 64'd0);
        chk("async_settling", 64'(settling), 64'd0);
        chk("async_chg",      64'(coarse_chg), 64'd0);
        chk("async_sat",      64'({sat_hi, sat_lo}), 64'd0);
        model_reset();
        step(1, 1, 0, 3000);
        step(1, 0, 0, 0);

`ifdef DCO_ENC_DWA_EN
        cur_tag = 6;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 48);
        cur_tag = 0;
        step(1, 0, 0, 0);
        step(0, 1, 0, 48);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            longint d;
            bit r, v, h;
            r = ($urandom_range(99) == 0);
            v = ($urandom_range(3) != 0);
            h = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0: d = longint'($urandom_range(200)) - 100;
                1: d = longint'($urandom_range(63)) * 1024 - 32768 + longint'($urandom_range(8)) - 4;
                2: d = longint'($signed($urandom()));
                default: d = ($urandom_range(1) == 1 ? 32767 : -32768) + longint'($urandom_range(20)) - 10;
            endcase
            step(r, v, h, d);
        end

        @(negedge refclk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("dither_three_count", 64'(t2_three), 64'd5);
        chk("dither_two_count",   64'(t2_two), 64'd11);
        chk("settle_high_cycles", 64'(t3_settle), 64'd4);
        chk("coarse_chg_pulses",  64'(t3_chg), 64'd1);
        chk("hold_settle_frozen", 64'(t5_settle), 64'd10);
        chk("hold_no_chg",        64'(t5_chg), 64'd0);
`ifdef DCO_ENC_DWA_EN
        chk("dwa_count", 64'(dwa_idx), 64'd3);
        chk("dwa_0", dwa_seen[0], 64'h7);
        chk("dwa_1", dwa_seen[1], 64'h38);
        chk("dwa_2", dwa_seen[2], 64'h1C0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
